// File: rtl/illness_pkg.sv
// rtl/illness_pkg.sv - shared state encodings and action masks for the illness episode tracker
package illness_pkg;

  // Episode phases; the numeric values are exported on the state port.
  typedef enum logic [1:0] {
    ST_HEALTHY = 2'd0,
    ST_SICK    = 2'd1,
    ST_CONV    = 2'd2,
    ST_IMMUNE  = 2'd3
  } ill_state_t;

  localparam logic [7:0] MASK_SICK = 8'h0F;
  localparam logic [7:0] MASK_CONV = 8'h3F;
  localparam logic [7:0] MASK_FREE = 8'hFF;

  function automatic logic [7:0] mask_for(input ill_state_t s);
    case (s)
      ST_SICK: mask_for = MASK_SICK;
      ST_CONV: mask_for = MASK_CONV;
      default: mask_for = MASK_FREE;
    endcase
  endfunction

endpackage

// File: rtl/phase_counter.sv
// rtl/phase_counter.sv - tick-driven phase counter saturating at a programmable limit
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clear     : restart the count; a tick in the same cycle is counted from zero
//   tick      : time-base pulse
//   limit     : saturation value
//   done      : count has reached limit
module phase_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       tick,
  input  logic [7:0] limit,
  output logic       done
);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= {7'd0, tick};
    end else if (tick && (count < limit)) begin
      count <= count + 8'd1;
    end
  end

  assign done = (count >= limit);

endmodule

// File: rtl/illness_episode_tracker.sv
// rtl/illness_episode_tracker.sv - illness episode FSM with medicine request and episode log
// Parameters: MED_THRESH, CONV_TICKS, IMMUNE_TICKS (ticks)
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   ill, tick      : illness flag, time-base pulse
//   med_ack        : medicine acknowledge
//   med_req        : medicine request (once per episode)
//   state          : 0 HEALTHY, 1 SICK, 2 CONVALESCENT, 3 IMMUNE
//   rest_demand    : state is SICK
//   action_mask    : allowed actions for the current state
//   episode_count  : saturating episode count (log build only, else 0)
//   max_duration   : longest SICK duration in ticks (log build only, else 0)
// Build option: define ILLNESS_EPISODE_LOG_EN to implement episode_count/max_duration.
module illness_episode_tracker
  import illness_pkg::*;
#(
  parameter int MED_THRESH   = 16,
  parameter int CONV_TICKS   = 8,
  parameter int IMMUNE_TICKS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ill,
  input  logic       tick,
  input  logic       med_ack,
  output logic       med_req,
  output logic [1:0] state,
  output logic       rest_demand,
  output logic [7:0] action_mask,
  output logic [3:0] episode_count,
  output logic [7:0] max_duration
);

  localparam logic [7:0] MED_LIM  = 8'(MED_THRESH);
  localparam logic [7:0] CONV_LIM = 8'(CONV_TICKS);
  localparam logic [7:0] IMM_LIM  = 8'(IMMUNE_TICKS);

  ill_state_t state_q;
  ill_state_t state_d;
  logic       new_episode;
  logic       ph_done;
  logic       ph_clear;
  logic       ph_tick;
  logic [7:0] ph_limit;
  logic [7:0] duration;
  logic       med_done;

  // A state change always wins over the tick of the state being left.
  always_comb begin
    state_d     = state_q;
    new_episode = 1'b0;
    case (state_q)
      ST_HEALTHY: begin
        if (ill) begin
          state_d     = ST_SICK;
          new_episode = 1'b1;
        end
      end
      ST_SICK: begin
        if (!ill) state_d = ST_CONV;
      end
      ST_CONV: begin
        if (ill)          state_d = ST_SICK;
        else if (ph_done) state_d = ST_IMMUNE;
      end
      ST_IMMUNE: begin
        if (ill) begin
          state_d     = ST_SICK;
          new_episode = 1'b1;
        end else if (ph_done) begin
          state_d = ST_HEALTHY;
        end
      end
      default: state_d = ST_HEALTHY;
    endcase
  end

  // Any state change restarts the phase count; a coincident tick lands in
  // the new state's count only if that state is a timed one.
  assign ph_clear = (state_d != state_q);
  assign ph_tick  = tick && ((state_d == ST_CONV) || (state_d == ST_IMMUNE));
  assign ph_limit = (state_q == ST_IMMUNE) ? IMM_LIM : CONV_LIM;

  phase_counter u_phase (
    .clk   (clk),
    .rst   (rst),
    .clear (ph_clear),
    .tick  (ph_tick),
    .limit (ph_limit),
    .done  (ph_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_HEALTHY;
    end else begin
      state_q <= state_d;
    end
  end

  // Duration restarts only for a new episode; a relapse keeps counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      duration <= 8'd0;
    end else if (new_episode) begin
      duration <= {7'd0, tick};
    end else if ((state_d == ST_SICK) && tick && (duration != 8'hFF)) begin
      duration <= duration + 8'd1;
    end
  end

  // med_done remembers that this episode already asked, so a relapse
  // past the threshold does not ask again.
  always_ff @(posedge clk) begin
    if (rst) begin
      med_req  <= 1'b0;
      med_done <= 1'b0;
    end else begin
      if (med_req && med_ack) med_req <= 1'b0;
      if ((state_q == ST_SICK) && (duration == MED_LIM) && !med_done) begin
        med_req  <= 1'b1;
        med_done <= 1'b1;
      end else if (new_episode) begin
        med_done <= 1'b0;
      end
    end
  end

`ifdef ILLNESS_EPISODE_LOG_EN
  logic sick_exit;
  assign sick_exit = (state_q == ST_SICK) && (state_d == ST_CONV);

  always_ff @(posedge clk) begin
    if (rst) begin
      episode_count <= 4'd0;
      max_duration  <= 8'd0;
    end else begin
      if (new_episode && (episode_count != 4'hF)) episode_count <= episode_count + 4'd1;
      if (sick_exit && (duration > max_duration)) max_duration <= duration;
    end
  end
`else
  assign episode_count = 4'd0;
  assign max_duration  = 8'd0;
`endif

  assign state       = state_q;
  assign rest_demand = (state_q == ST_SICK);
  assign action_mask = mask_for(state_q);

endmodule

// File: tb/tb_illness_episode_tracker.sv
// tb/tb_illness_episode_tracker.sv - self-checking bench for illness_episode_tracker
module tb_illness_episode_tracker;

  localparam int MED  = 16;
  localparam int CONV = 8;
  localparam int IMM  = 16;
`ifdef ILLNESS_EPISODE_LOG_EN
  localparam bit LOG = 1'b1;
`else
  localparam bit LOG = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ill = 1'b0;
  logic       tick = 1'b0;
  logic       med_ack = 1'b0;
  logic       med_req;
  logic [1:0] state;
  logic       rest_demand;
  logic [7:0] action_mask;
  logic [3:0] episode_count;
  logic [7:0] max_duration;

  int checks = 0;
  int failures = 0;

  // Reference model: episode bookkeeping in plain integers.
  int m_state = 0, m_dur = 0, m_ph = 0, m_ec = 0, m_max = 0;
  bit m_med = 0, m_asked = 0;

  illness_episode_tracker #(.MED_THRESH(MED), .CONV_TICKS(CONV), .IMMUNE_TICKS(IMM)) dut (
    .clk           (clk),
    .rst           (rst),
    .ill           (ill),
    .tick          (tick),
    .med_ack       (med_ack),
    .med_req       (med_req),
    .state         (state),
    .rest_demand   (rest_demand),
    .action_mask   (action_mask),
    .episode_count (episode_count),
    .max_duration  (max_duration)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_step(input bit r, input bit i, input bit t, input bit a);
    if (r) begin
      m_state = 0; m_dur = 0; m_ph = 0; m_ec = 0; m_max = 0; m_med = 0; m_asked = 0;
    end else begin
      if (m_med && a) m_med = 0;
      if (m_state == 1 && m_dur == MED && !m_asked) begin
        m_med = 1; m_asked = 1;
      end
      case (m_state)
        0: if (i) begin m_state = 1; m_ec = sat(m_ec + 1, 15); m_dur = t; m_asked = 0; end
        1: if (!i) begin
             m_state = 2; m_ph = t;
             if (m_dur > m_max) m_max = m_dur;
           end else m_dur = sat(m_dur + t, 255);
        2: if (i) begin m_state = 1; m_ph = 0; m_dur = sat(m_dur + t, 255); end
           else if (m_ph >= CONV) begin m_state = 3; m_ph = t; end
           else m_ph = sat(m_ph + t, CONV);
        default: if (i) begin
             m_state = 1; m_ph = 0; m_ec = sat(m_ec + 1, 15); m_dur = t; m_asked = 0;
           end else if (m_ph >= IMM) begin m_state = 0; m_ph = 0; end
           else m_ph = sat(m_ph + t, IMM);
      endcase
    end
  endtask

  task automatic compare_all();
    int mask;
    mask = (m_state == 1) ? 'h0F : (m_state == 2) ? 'h3F : 'hFF;
    check("state", 32'(state), 32'(m_state));
    check("med_req", 32'(med_req), 32'(m_med));
    check("rest_demand", 32'(rest_demand), 32'(m_state == 1));
    check("action_mask", 32'(action_mask), 32'(mask));
    check("episode_count", 32'(episode_count), LOG ? 32'(m_ec) : 32'd0);
    check("max_duration", 32'(max_duration), LOG ? 32'(m_max) : 32'd0);
  endtask

  // One clock: drive inputs, model the edge, compare on the falling edge.
  task automatic step(input bit r, input bit i, input bit t, input bit a);
    rst = r; ill = i; tick = t; med_ack = a;
    @(posedge clk);
    model_step(r, i, t, a);
    @(negedge clk);
    compare_all();
  endtask

  task automatic ticks(input int n, input bit i);
    for (int k = 0; k < n; k++) begin
      step(0, i, 1, 0);
      step(0, i, 0, 0);
    end
  endtask

  initial begin
    @(negedge clk);
    // Reset values
    step(1, 0, 0, 0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_mask", 32'(action_mask), 32'hFF);
    check("rst_med", 32'(med_req), 32'd0);
    check("rst_ec", 32'(episode_count), 32'd0);

    // Onset
    step(0, 1, 0, 0);
    check("onset_state", 32'(state), 32'd1);
    check("onset_ec", 32'(episode_count), LOG ? 32'd1 : 32'd0);
    check("onset_rest", 32'(rest_demand), 32'd1);
    check("onset_mask", 32'(action_mask), 32'h0F);

    // Medicine request after 16 ticks, held until ack, never repeated
    ticks(15, 1);
    check("med_early", 32'(med_req), 32'd0);
    ticks(1, 1);
    check("med_raised", 32'(med_req), 32'd1);
    for (int k = 0; k < 5; k++) step(0, 1, 0, 0);
    check("med_held", 32'(med_req), 32'd1);
    step(0, 1, 0, 1);
    check("med_acked", 32'(med_req), 32'd0);
    ticks(24, 1);
    check("med_no_repeat", 32'(med_req), 32'd0);

    // Full episode: 20 ticks, convalescence, immunity, recovery
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    ticks(20, 1);
    step(0, 0, 0, 1);
    check("conv_state", 32'(state), 32'd2);
    check("conv_max", 32'(max_duration), LOG ? 32'd20 : 32'd0);
    check("conv_mask", 32'(action_mask), 32'h3F);
    ticks(CONV, 0);
    check("immune_state", 32'(state), 32'd3);
    ticks(IMM, 0);
    check("healthy_state", 32'(state), 32'd0);
    check("healthy_mask", 32'(action_mask), 32'hFF);

    // Relapse at convalescent tick 3 keeps the episode and duration
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    ticks(20, 1);
    step(0, 1, 0, 1);
    step(0, 0, 0, 0);
    ticks(3, 0);
    step(0, 1, 0, 0);
    check("relapse_state", 32'(state), 32'd1);
    check("relapse_ec", 32'(episode_count), LOG ? 32'd1 : 32'd0);
    ticks(1, 1);
    step(0, 0, 0, 0);
    check("relapse_max", 32'(max_duration), LOG ? 32'd21 : 32'd0);
    check("relapse_no_med", 32'(med_req), 32'd0);

    // Relapse before threshold: duration must keep counting toward it
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    ticks(10, 1);
    step(0, 0, 0, 0);
    ticks(2, 0);
    step(0, 1, 0, 0);
    ticks(6, 1);
    check("relapse_med", 32'(med_req), 32'd1);

    // 17 episodes: count saturates at 15
    step(1, 0, 0, 0);
    for (int e = 0; e < 17; e++) begin
      step(0, 1, 0, 0);
      step(0, 0, 0, 0);
      ticks(CONV, 0);
    end
    check("ec_saturated", 32'(episode_count), LOG ? 32'd15 : 32'd0);

    // Reset abandons a pending request
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    ticks(16, 1);
    step(0, 1, 0, 0);
    check("pre_rst_med", 32'(med_req), 32'd1);
    step(1, 1, 1, 0);
    check("mid_rst_state", 32'(state), 32'd0);
    check("mid_rst_med", 32'(med_req), 32'd0);
    check("mid_rst_mask", 32'(action_mask), 32'hFF);
    check("mid_rst_ec", 32'(episode_count), 32'd0);
    check("mid_rst_max", 32'(max_duration), 32'd0);

    // Randomized traffic against the model
    begin
      bit ri;
      ri = 0;
      for (int c = 0; c < 4000; c++) begin
        if ($urandom_range(0, 24) == 0) ri = ~ri;
        step(($urandom_range(0, 799) == 0), ri, ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 7) == 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
